// File: rtl/fb_write_ctrl_if.sv
// Renderer-to-controller pixel handshake and controller-to-framebuffer write bus.
// The master side is the renderer, and the slave side is fb_write_ctrl.
interface fb_write_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 12
);
    logic                  draw_valid;
    logic                  draw_ready;
    logic [ADDR_WIDTH-1:0] draw_addr;
    logic [DATA_WIDTH-1:0] draw_data;
    logic                  draw_last;
    logic                  wr_en;
    logic                  wr_buffer;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output draw_valid, draw_addr, draw_data, draw_last,
        input  draw_ready, wr_en, wr_buffer, wr_addr, wr_data
    );

    modport slave (
        input  draw_valid, draw_addr, draw_data, draw_last,
        output draw_ready, wr_en, wr_buffer, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_write_ctrl.sv
// Double-buffered framebuffer write controller. Each frame has an optional clear pass
// and a pixel draw pass, then waits until the display swaps to the drawn buffer.
module fb_write_ctrl #(
    parameter int                           BUFFER_WIDTH      = 160,
    parameter int                           BUFFER_HEIGHT     = 120,
    parameter int                           BUFFER_DATA_WIDTH = 12,
    parameter int                           BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
    parameter logic [BUFFER_DATA_WIDTH-1:0] CLEAR_COLOR       = BUFFER_DATA_WIDTH'(12'h000),
    parameter bit                           CLEAR_EN          = 1'b1
) (
    input  logic           clk_pixel,
    input  logic           rstn_pixel,
    input  logic           buffer_select,
    input  logic           frame_start,
    fb_write_ctrl_if.slave bus,
    output logic           busy,
    output logic           frame_done,
    output logic           tear_err,
    output logic           oob_err
);
    localparam int unsigned                  PIXEL_COUNT   = BUFFER_WIDTH * BUFFER_HEIGHT;
    localparam logic [BUFFER_ADDR_WIDTH:0]   PIXEL_COUNT_W = (BUFFER_ADDR_WIDTH+1)'(PIXEL_COUNT);
    localparam logic [BUFFER_ADDR_WIDTH-1:0] CLEAR_LAST    = BUFFER_ADDR_WIDTH'(PIXEL_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_DRAW      = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } state_t;

    state_t                       state_r, state_next_s;
    logic                         target_r, target_s;
    logic [BUFFER_ADDR_WIDTH-1:0] clear_cnt_r, clear_cnt_s;
    logic                         wr_en_r, wr_en_s;
    logic                         wr_buffer_r, wr_buffer_s;
    logic [BUFFER_ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
    logic [BUFFER_DATA_WIDTH-1:0] wr_data_r, wr_data_s;
    logic                         draw_ready_r, draw_ready_s;
    logic                         busy_r, busy_s;
    logic                         frame_done_r, frame_done_s;
    logic                         tear_err_r, tear_err_s;
    logic                         oob_err_r, oob_err_s;

    logic accept_s;
    logic addr_oob_s;
    logic swapped_s;

    assign accept_s   = bus.draw_valid & draw_ready_r;
    assign addr_oob_s = {1'b0, bus.draw_addr} >= PIXEL_COUNT_W;
    assign swapped_s  = buffer_select != target_r;

    // State register
    always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
        if (!rstn_pixel) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next_s = CLEAR_EN ? ST_CLEAR : ST_DRAW;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clear_cnt_r == CLEAR_LAST) begin
                    state_next_s = ST_DRAW;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_DRAW: begin
                if (accept_s && bus.draw_last) begin
                    state_next_s = ST_WAIT_SWAP;
                end else begin
                    state_next_s = ST_DRAW;
                end
            end
            ST_WAIT_SWAP: begin
                if (swapped_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_SWAP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output and datapath decode. Writes are staged here, so they appear on the
    // registered outputs in the cycle that follows the deciding edge.
    always_comb begin
        target_s     = target_r;
        clear_cnt_s  = clear_cnt_r;
        wr_en_s      = 1'b0;
        wr_buffer_s  = wr_buffer_r;
        wr_addr_s    = wr_addr_r;
        wr_data_s    = wr_data_r;
        frame_done_s = 1'b0;
        tear_err_s   = tear_err_r;
        oob_err_s    = oob_err_r;
        draw_ready_s = state_next_s == ST_DRAW;
        busy_s       = state_next_s != ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    target_s    = buffer_select;
                    tear_err_s  = 1'b0;
                    oob_err_s   = 1'b0;
                    clear_cnt_s = '0;
                    if (CLEAR_EN) begin
                        wr_en_s     = 1'b1;
                        wr_buffer_s = buffer_select;
                        wr_addr_s   = '0;
                        wr_data_s   = CLEAR_COLOR;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end else begin
                    target_s = target_r;
                end
            end
            ST_CLEAR: begin
                tear_err_s = tear_err_r | swapped_s;
                if (clear_cnt_r != CLEAR_LAST) begin
                    clear_cnt_s = clear_cnt_r + BUFFER_ADDR_WIDTH'(1);
                    wr_en_s     = 1'b1;
                    wr_buffer_s = target_r;
                    wr_addr_s   = clear_cnt_r + BUFFER_ADDR_WIDTH'(1);
                    wr_data_s   = CLEAR_COLOR;
                end else begin
                    clear_cnt_s = clear_cnt_r;
                end
            end
            ST_DRAW: begin
                tear_err_s = tear_err_r | swapped_s;
                if (accept_s && addr_oob_s) begin
                    oob_err_s = 1'b1;
                end else if (accept_s) begin
                    wr_en_s     = 1'b1;
                    wr_buffer_s = target_r;
                    wr_addr_s   = bus.draw_addr;
                    wr_data_s   = bus.draw_data;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_WAIT_SWAP: begin
                frame_done_s = swapped_s;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
        if (!rstn_pixel) begin
            target_r     <= 1'b0;
            clear_cnt_r  <= '0;
            wr_en_r      <= 1'b0;
            wr_buffer_r  <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            draw_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            tear_err_r   <= 1'b0;
            oob_err_r    <= 1'b0;
        end else begin
            target_r     <= target_s;
            clear_cnt_r  <= clear_cnt_s;
            wr_en_r      <= wr_en_s;
            wr_buffer_r  <= wr_buffer_s;
            wr_addr_r    <= wr_addr_s;
            wr_data_r    <= wr_data_s;
            draw_ready_r <= draw_ready_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
            tear_err_r   <= tear_err_s;
            oob_err_r    <= oob_err_s;
        end
    end

    assign bus.draw_ready = draw_ready_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_buffer  = wr_buffer_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign busy           = busy_r;
    assign frame_done     = frame_done_r;
    assign tear_err       = tear_err_r;
    assign oob_err        = oob_err_r;
endmodule
